// File: rtl/controlador_barrido.sv
// controlador_barrido: 8-digit 7-segment scan sequencer with blanking, PWM brightness and frame-synchronous double buffering.
// Optional leading-zero suppression is enabled by defining SUPRIMIR_CEROS_EN.
module controlador_barrido #(
    parameter int DIV_TICK  = 100000,
    parameter int BLANK_CYC = 16,
    parameter int N_DIG     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] datos_in,
    input  logic        cargar,
    input  logic [7:0]  habilitar_dig,
    input  logic [2:0]  brillo,
    output logic [7:0]  anodo,
    output logic [3:0]  digito,
    output logic [2:0]  indice,
    output logic        fin_cuadro,
    output logic        pendiente
);
    localparam int CW = $clog2(DIV_TICK);
    localparam logic [CW-1:0] LAST = CW'(DIV_TICK - 1);
    localparam logic [CW-1:0] STEP = CW'((DIV_TICK - BLANK_CYC) >> 3);
    localparam logic [2:0] IDX_LAST = 3'(N_DIG - 1);

    typedef enum logic [1:0] {S_BLANK, S_ON, S_OFF} estado_t;

    estado_t        state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, on_end;
    logic [2:0]     idx_q, idx_d, brillo_q, brillo_d;
    logic [7:0]     anodo_q, anodo_d;
    logic [3:0]     digito_q, digito_d;
    logic           fin_q, fin_d, pend_q, pend_d, wrap, xfer, vis;
    logic [31:0]    act_q, act_d, sh_q, sh_d;

`ifdef SUPRIMIR_CEROS_EN
    logic [7:0] mask_q, mask_d, elig;
    logic       nz;
    // A digit is eligible if it or any more significant nibble is nonzero; digit 0 always is.
    always_comb begin
        nz = 1'b0;
        elig = 8'h01;
        for (int i = 7; i >= 1; i--) begin
            nz = nz | (sh_q[4*i +: 4] != 4'd0);
            elig[i] = nz;
        end
        mask_d = xfer ? elig : mask_q;
    end
    always_ff @(posedge clk)
        mask_q <= rst ? 8'h01 : mask_d;
    assign vis = habilitar_dig[idx_d] & mask_q[idx_d];
`else
    assign vis = habilitar_dig[idx_d];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_BLANK;
            cnt_q    <= '0;
            idx_q    <= '0;
            brillo_q <= '0;
            anodo_q  <= 8'hFF;
            digito_q <= '0;
            fin_q    <= 1'b0;
            pend_q   <= 1'b0;
            act_q    <= '0;
            sh_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            brillo_q <= brillo_d;
            anodo_q  <= anodo_d;
            digito_q <= digito_d;
            fin_q    <= fin_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
            sh_q     <= sh_d;
        end
    end

    // Outputs are computed from next-state values so the registered anodes line up with cnt.
    always_comb begin
        wrap     = cnt_q == LAST;
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? ((idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1) : idx_q;
        brillo_d = (cnt_q == '0) ? brillo : brillo_q;
        digito_d = (cnt_q == '0) ? act_q[4*idx_q +: 4] : digito_q;
        on_end   = CW'(BLANK_CYC - 1) + STEP * (CW'(brillo_q) + CW'(1));
        state_d  = (state_q == S_BLANK) ? ((cnt_q == CW'(BLANK_CYC - 1)) ? S_ON : S_BLANK)
                 : wrap ? S_BLANK
                 : (state_q == S_ON && cnt_q == on_end) ? S_OFF : state_q;
        anodo_d  = (state_d == S_ON && vis) ? ~(8'd1 << idx_d) : 8'hFF;
        fin_d    = (cnt_d == LAST) && (idx_d == IDX_LAST);
        xfer     = fin_q & pend_q;
        act_d    = xfer ? sh_q : act_q;
        sh_d     = cargar ? datos_in : sh_q;
        pend_d   = cargar | (pend_q & ~fin_q);
    end

    assign anodo      = anodo_q;
    assign digito     = digito_q;
    assign indice     = idx_q;
    assign fin_cuadro = fin_q;
    assign pendiente  = pend_q;
endmodule

// File: tb/tb_controlador_barrido.sv
// tb_controlador_barrido: directed checks of scan timing, brightness, buffering and reset with DIV_TICK=20, BLANK_CYC=4.
module tb_controlador_barrido;
    localparam int NONE = 999;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] datos_in;
    logic        cargar;
    logic [7:0]  habilitar_dig;
    logic [2:0]  brillo;
    logic [7:0]  anodo;
    logic [3:0]  digito;
    logic [2:0]  indice;
    logic        fin_cuadro;
    logic        pendiente;
    int          total = 0;
    int          passed = 0;

    controlador_barrido #(.DIV_TICK(20), .BLANK_CYC(4), .N_DIG(8)) dut (
        .clk(clk), .rst(rst), .datos_in(datos_in), .cargar(cargar),
        .habilitar_dig(habilitar_dig), .brillo(brillo), .anodo(anodo),
        .digito(digito), .indice(indice), .fin_cuadro(fin_cuadro), .pendiente(pendiente)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_fin();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fin_cuadro !== 1'b1 && n < 400);
        chk("wait_fin", fin_cuadro, 1);
    endtask

    // Entered and left on the negedge of a fin_cuadro cycle; checks one full 160-cycle frame.
    task automatic frame(input logic [31:0] shown, input int br, input logic [7:0] vis,
                         input logic pend0, input int ia, input logic [31:0] va,
                         input int ib, input logic [31:0] vb);
        for (int t = 0; t < 160; t++) begin
            int s, k;
            logic [7:0] an_exp;
            @(negedge clk);
            s = t / 20;
            k = t % 20;
            an_exp = (k >= 4 && k < 4 + 2 * (br + 1) && vis[s]) ? ~(8'd1 << s) : 8'hFF;
            chk("anodo", anodo, an_exp);
            chk("indice", indice, s);
            chk("fin_cuadro", fin_cuadro, t == 159);
            chk("pendiente", pendiente, pend0 || t > ia || t > ib);
            if (k >= 1) chk("digito", digito, shown[4*s +: 4]);
            cargar = (t == ia) || (t == ib);
            datos_in = (t == ib) ? vb : va;
        end
    endtask

    initial begin
        rst = 1'b1;
        cargar = 1'b0;
        datos_in = '0;
        habilitar_dig = 8'hFF;
        brillo = 3'd7;
        repeat (3) @(negedge clk);
        chk("rst_anodo", anodo, 8'hFF);
        chk("rst_indice", indice, 0);
        chk("rst_digito", digito, 0);
        chk("rst_fin", fin_cuadro, 0);
        chk("rst_pend", pendiente, 0);
        rst = 1'b0;
        datos_in = 32'h76543210;
        cargar = 1'b1;
        @(negedge clk);
        cargar = 1'b0;
        chk("load_pend", pendiente, 1);
        chk("load_digito", digito, 0);
        wait_fin();
        chk("fin_pend", pendiente, 1);
        frame(32'h76543210, 7, 8'hFF, 0, NONE, 0, NONE, 0);
        brillo = 3'd0;
        frame(32'h76543210, 0, 8'hFF, 0, NONE, 0, NONE, 0);
        brillo = 3'd3;
        frame(32'h76543210, 3, 8'hFF, 0, NONE, 0, NONE, 0);
        brillo = 3'd7;
        frame(32'h76543210, 7, 8'hFF, 0, 37, 32'hAAAAAAAA, NONE, 0);
        frame(32'hAAAAAAAA, 7, 8'hFF, 0, 159, 32'h11111111, NONE, 0);
        frame(32'hAAAAAAAA, 7, 8'hFF, 1, 159, 32'h22222222, NONE, 0);
        frame(32'h11111111, 7, 8'hFF, 1, NONE, 0, NONE, 0);
        frame(32'h22222222, 7, 8'hFF, 0, 10, 32'h33333333, 20, 32'h44444444);
        habilitar_dig = 8'b0000_0101;
        frame(32'h44444444, 7, 8'h05, 0, 100, 32'h00000305, NONE, 0);
        habilitar_dig = 8'hFF;
`ifdef SUPRIMIR_CEROS_EN
        frame(32'h00000305, 7, 8'h07, 0, 100, 32'h00000000, NONE, 0);
        frame(32'h00000000, 7, 8'h01, 0, NONE, 0, NONE, 0);
`else
        frame(32'h00000305, 7, 8'hFF, 0, 100, 32'h00000000, NONE, 0);
        frame(32'h00000000, 7, 8'hFF, 0, NONE, 0, NONE, 0);
`endif
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            cargar = (i == 5);
            datos_in = 32'h99999999;
        end
        chk("mid_anodo", anodo, 8'hFE);
        chk("mid_pend", pendiente, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_anodo", anodo, 8'hFF);
        chk("mrst_indice", indice, 0);
        chk("mrst_pend", pendiente, 0);
        chk("mrst_digito", digito, 0);
        chk("mrst_fin", fin_cuadro, 0);
        rst = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
